// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard sequencer.
// The FSM only leaves RUN to carry a redirect across a cache stall.
package pipeline_hazard_ctrl_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_WID = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } hazard_state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_det.sv
// Load-use detector: ID instruction reads a register that the load in EX has not yet produced.
// Register 0 is hard-wired to zero, so it never creates a hazard.
module hazard_load_use_det #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  output logic             o_load_use
);
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: merges cache stalls, load-use and mispredicts into per-stage
// hold/flush strobes and a PC redirect, deferring a redirect across cache stalls.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = pipeline_hazard_ctrl_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_icache_stall,
  input  logic                i_dcache_stall,
  input  logic [REG_W-1:0]    i_id_rs1,
  input  logic [REG_W-1:0]    i_id_rs2,
  input  logic                i_id_use_rs1,
  input  logic                i_id_use_rs2,
  input  logic [REG_W-1:0]    i_ex_rd,
  input  logic                i_ex_mem_read,
  input  logic                i_predict_fail,
  input  logic [DATA_WID-1:0] i_fix_pc,
  output logic                o_pc_hold,
  output logic                o_pc_redirect,
  output logic [DATA_WID-1:0] o_redirect_pc,
  output logic                o_if_id_hold,
  output logic                o_if_id_flush,
  output logic                o_id_ex_hold,
  output logic                o_id_ex_flush,
  output logic                o_ex_mem_hold,
  output logic                o_mem_wb_hold,
  output logic [CNT_W-1:0]    o_stall_cycles,
  output logic [CNT_W-1:0]    o_flush_count
);
  hazard_state_e       r_state;
  hazard_state_e       w_state_nxt;
  hazard_state_e       w_state_eff;
  logic                r_pend_vld;
  logic [DATA_WID-1:0] r_pend_pc;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic                w_load_use;
  logic                w_pend_set;
  logic                w_pend_clr;
  logic [DATA_WID-1:0] w_pend_val;
  logic [DATA_WID-1:0] w_target;
  logic                w_flush_inc;
  logic                w_any_hold;

  logic                w_pc_hold, w_pc_redirect, w_if_id_hold, w_if_id_flush;
  logic                w_id_ex_hold, w_id_ex_flush, w_ex_mem_hold, w_mem_wb_hold;
  logic [DATA_WID-1:0] w_redirect_pc;

  hazard_load_use_det #(.REG_W(REG_W)) u_load_use_det (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_mem_read (i_ex_mem_read),
    .o_load_use    (w_load_use)
  );

  // A live mispredict is younger than any pending one, so its target wins.
  assign w_target = i_predict_fail ? i_fix_pc : r_pend_pc;

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_set    = 1'b0;
    w_pend_clr    = 1'b0;
    w_pend_val    = i_fix_pc;
    w_flush_inc   = 1'b0;
    w_pc_hold     = 1'b0;
    w_pc_redirect = 1'b0;
    w_redirect_pc = '0;
    w_if_id_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_hold  = 1'b0;
    w_id_ex_flush = 1'b0;
    w_ex_mem_hold = 1'b0;
    w_mem_wb_hold = 1'b0;
    // Leaving DWAIT with nothing pending behaves exactly like RUN in that cycle.
    w_state_eff   = (r_state == DWAIT && !i_dcache_stall && !r_pend_vld) ? RUN : r_state;

    if (!i_rst) begin
      if (i_dcache_stall) begin
        w_pc_hold     = 1'b1;
        w_if_id_hold  = 1'b1;
        w_id_ex_hold  = 1'b1;
        w_ex_mem_hold = 1'b1;
        w_mem_wb_hold = 1'b1;
        w_pend_set    = i_predict_fail;
        if (w_state_eff == RUN) w_state_nxt = DWAIT;
      end else begin
        case (w_state_eff)
          RUN: begin
            w_state_nxt = RUN;
            if (i_predict_fail && i_icache_stall) begin
              w_pend_set    = 1'b1;
              w_pc_hold     = 1'b1;
              w_if_id_flush = 1'b1;
              w_id_ex_flush = 1'b1;
              w_state_nxt   = IWAIT;
            end else if (i_predict_fail) begin
              w_pc_redirect = 1'b1;
              w_redirect_pc = i_fix_pc;
              w_if_id_flush = 1'b1;
              w_id_ex_flush = 1'b1;
              w_flush_inc   = 1'b1;
            end else if (i_icache_stall) begin
              w_pc_hold     = 1'b1;
              w_if_id_flush = 1'b1;
            end else if (w_load_use) begin
              w_pc_hold     = 1'b1;
              w_if_id_hold  = 1'b1;
              w_id_ex_flush = 1'b1;
            end
          end
          DWAIT, IWAIT: begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (i_icache_stall) begin
              w_pc_hold   = 1'b1;
              w_pend_set  = i_predict_fail;
              w_state_nxt = IWAIT;
            end else begin
              w_pc_redirect = 1'b1;
              w_redirect_pc = w_target;
              w_flush_inc   = 1'b1;
              w_pend_clr    = 1'b1;
              w_state_nxt   = RUN;
            end
          end
          default: w_state_nxt = RUN;
        endcase
      end
    end
  end

  assign w_any_hold = w_pc_hold | w_if_id_hold | w_id_ex_hold | w_ex_mem_hold | w_mem_wb_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_pend_vld  <= 1'b0;
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pend_set) begin
        r_pend_vld <= 1'b1;
        r_pend_pc  <= w_pend_val;
      end else if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end
      if (w_any_hold)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_pc_hold      = w_pc_hold;
  assign o_pc_redirect  = w_pc_redirect;
  assign o_redirect_pc  = w_redirect_pc;
  assign o_if_id_hold   = w_if_id_hold;
  assign o_if_id_flush  = w_if_id_flush;
  assign o_id_ex_hold   = w_id_ex_hold;
  assign o_id_ex_flush  = w_id_ex_flush;
  assign o_ex_mem_hold  = w_ex_mem_hold;
  assign o_mem_wb_hold  = w_mem_wb_hold;
  assign o_stall_cycles = r_stall_cnt;
  assign o_flush_count  = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed vector table, hand sequences for deferred redirects and reset,
// then random traffic against a pending-redirect reference model.
module tb_pipeline_hazard_ctrl;
  // strobe vector order: {pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold}
  localparam logic [7:0] S0  = 8'b0000_0000;
  localparam logic [7:0] SAH = 8'b1010_1011;
  localparam logic [7:0] SLU = 8'b1010_0100;
  localparam logic [7:0] SRD = 8'b0101_0100;
  localparam logic [7:0] SIC = 8'b1001_0000;
  localparam logic [7:0] SIW = 8'b1001_0100;

  typedef struct {
    bit        ic, dc, mr, u1, u2, pf;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] fpc;
    bit [7:0]  es;
    bit [31:0] er;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic = 0, dc = 0, u1 = 0, u2 = 0, mr = 0, pf = 0;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
  logic [31:0] fpc = 0;
  logic        pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold;
  logic [31:0] redirect_pc, stall_cycles, flush_count;
  logic [7:0]  str;

  int checks = 0;
  int errors = 0;

  bit          m_pend, n_pend;
  bit [31:0]   m_pc, n_pc, m_stall, n_stall, m_flush, n_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_icache_stall(ic), .i_dcache_stall(dc),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
    .i_ex_rd(rd), .i_ex_mem_read(mr), .i_predict_fail(pf), .i_fix_pc(fpc),
    .o_pc_hold(pc_hold), .o_pc_redirect(pc_redirect), .o_redirect_pc(redirect_pc),
    .o_if_id_hold(if_id_hold), .o_if_id_flush(if_id_flush), .o_id_ex_hold(id_ex_hold),
    .o_id_ex_flush(id_ex_flush), .o_ex_mem_hold(ex_mem_hold), .o_mem_wb_hold(mem_wb_hold),
    .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  assign str = {pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_hold};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit i_c, bit d_c, bit p_f, bit [31:0] f_pc, bit [7:0] e_s, bit [31:0] e_r);
    vec_t v;
    v = '{ic: i_c, dc: d_c, mr: 0, u1: 0, u2: 0, pf: p_f, rs1: 0, rs2: 0, rd: 0, fpc: f_pc, es: e_s, er: e_r};
    return v;
  endfunction

  function automatic vec_t mkl(bit i_c, bit m_r, bit [4:0] r1, bit use1, bit [4:0] r2, bit use2, bit [4:0] d,
                               bit p_f, bit [31:0] f_pc, bit [7:0] e_s, bit [31:0] e_r);
    vec_t v;
    v = '{ic: i_c, dc: 0, mr: m_r, u1: use1, u2: use2, pf: p_f, rs1: r1, rs2: r2, rd: d, fpc: f_pc, es: e_s, er: e_r};
    return v;
  endfunction

  // Reference: at most one redirect is ever owed; dcache freezes everything, otherwise an owed or
  // live redirect goes out unless fetch is stalled, in which case it stays owed.
  task automatic model_eval(input vec_t v, output logic [7:0] s, output logic [31:0] rpc);
    bit        lu;
    bit [31:0] tgt;
    lu = v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    s = S0; rpc = 0;
    n_pend = m_pend; n_pc = m_pc; n_flush = m_flush;
    if (v.dc) begin
      s = SAH;
      if (v.pf) begin n_pend = 1; n_pc = v.fpc; end
    end else if (m_pend || v.pf) begin
      tgt = v.pf ? v.fpc : m_pc;
      if (v.ic) begin s = SIW; n_pend = 1; n_pc = tgt; end
      else begin s = SRD; rpc = tgt; n_pend = 0; n_flush = m_flush + 1; end
    end else if (v.ic) s = SIC;
    else if (lu) s = SLU;
    n_stall = m_stall + ((s[7] | s[5] | s[3] | s[1] | s[0]) ? 32'd1 : 32'd0);
  endtask

  task automatic model_reset();
    m_pend = 0; m_pc = 0; m_stall = 0; m_flush = 0;
  endtask

  // One pipeline cycle: drive at negedge, check combinational strobes and counters before the posedge.
  task automatic cyc(input vec_t v, input bit use_table, input string nm);
    logic [7:0]  ms;
    logic [31:0] mr_pc;
    @(negedge clk);
    ic = v.ic; dc = v.dc; mr = v.mr; u1 = v.u1; u2 = v.u2; pf = v.pf;
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; fpc = v.fpc;
    #2;
    model_eval(v, ms, mr_pc);
    if (use_table) begin
      chk({nm, "_strobes"}, {24'd0, str}, {24'd0, v.es});
      if (v.es[6]) chk({nm, "_redirect_pc"}, redirect_pc, v.er);
    end else begin
      chk({nm, "_strobes"}, {24'd0, str}, {24'd0, ms});
      if (ms[6]) chk({nm, "_redirect_pc"}, redirect_pc, mr_pc);
    end
    chk({nm, "_stall_cycles"}, stall_cycles, m_stall);
    chk({nm, "_flush_count"}, flush_count, m_flush);
    m_pend = n_pend; m_pc = n_pc; m_stall = n_stall; m_flush = n_flush;
  endtask

  vec_t tab[$];
  vec_t rv;

  initial begin
    model_reset();
    #1;
    chk("reset_strobes", {24'd0, str}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    chk("reset_flush_count", flush_count, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Directed table: load-use variants, mispredict, icache bubble.
    tab.push_back(mkl(0, 0, 0, 0, 0, 0, 0, 0, 0, S0, 0));
    tab.push_back(mkl(0, 1, 5, 1, 0, 0, 5, 0, 0, SLU, 0));
    tab.push_back(mkl(0, 0, 5, 1, 0, 0, 5, 0, 0, S0, 0));
    tab.push_back(mkl(0, 1, 0, 1, 0, 0, 0, 0, 0, S0, 0));
    tab.push_back(mkl(0, 1, 0, 0, 7, 0, 7, 0, 0, S0, 0));
    tab.push_back(mkl(0, 1, 3, 0, 7, 1, 7, 0, 0, SLU, 0));
    tab.push_back(mkl(0, 1, 5, 1, 0, 0, 4, 0, 0, S0, 0));
    tab.push_back(mkl(0, 1, 5, 1, 0, 0, 5, 1, 32'h100, SRD, 32'h100));
    tab.push_back(mkl(1, 1, 5, 1, 0, 0, 5, 0, 0, SIC, 0));
    tab.push_back(mkl(0, 0, 0, 0, 0, 0, 0, 0, 0, S0, 0));
    foreach (tab[i]) cyc(tab[i], 1, $sformatf("tab%0d", i));

    // dcache stall with a mispredict deferred to the cycle the miss clears.
    cyc(mk(0, 1, 0, 0, SAH, 0), 1, "dw1");
    cyc(mk(0, 1, 1, 32'h200, SAH, 0), 1, "dw2");
    cyc(mk(0, 1, 0, 0, SAH, 0), 1, "dw3");
    cyc(mk(0, 1, 0, 0, SAH, 0), 1, "dw4");
    cyc(mk(0, 0, 0, 0, SRD, 32'h200), 1, "dw_exit");
    cyc(mk(0, 0, 0, 0, S0, 0), 1, "dw_after");

    // Mispredict during icache miss, then dcache exit into icache miss.
    cyc(mk(1, 0, 1, 32'h300, SIW, 0), 1, "iw1");
    cyc(mk(1, 0, 0, 0, SIW, 0), 1, "iw2");
    cyc(mk(1, 0, 0, 0, SIW, 0), 1, "iw3");
    cyc(mk(0, 0, 0, 0, SRD, 32'h300), 1, "iw_exit");
    cyc(mk(0, 1, 1, 32'h440, SAH, 0), 1, "di1");
    cyc(mk(1, 0, 0, 0, SIW, 0), 1, "di2");
    cyc(mk(1, 1, 0, 0, SAH, 0), 1, "di3");
    cyc(mk(1, 0, 1, 32'h480, SIW, 0), 1, "di4");
    cyc(mk(0, 0, 0, 0, SRD, 32'h480), 1, "di_exit");

    // Reset pulse in the middle of an IWAIT drops the pending redirect.
    cyc(mk(1, 0, 1, 32'hABC, SIW, 0), 1, "rw1");
    cyc(mk(1, 0, 0, 0, SIW, 0), 1, "rw2");
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_async_strobes", {24'd0, str}, 32'd0);
    chk("rst_async_redirect_pc", redirect_pc, 32'd0);
    chk("rst_async_stall_cycles", stall_cycles, 32'd0);
    chk("rst_async_flush_count", flush_count, 32'd0);
    ic = 0; pf = 0; fpc = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
    cyc(mk(0, 0, 0, 0, S0, 0), 1, "rst_no_redirect");
    cyc(mk(0, 0, 0, 0, S0, 0), 1, "rst_idle");

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rv.ic  = ($urandom_range(0, 3) == 0);
      rv.dc  = ($urandom_range(0, 4) == 0);
      rv.pf  = ($urandom_range(0, 7) == 0);
      rv.mr  = $urandom_range(0, 1);
      rv.u1  = $urandom_range(0, 1);
      rv.u2  = $urandom_range(0, 1);
      rv.rs1 = 5'($urandom_range(0, 3));
      rv.rs2 = 5'($urandom_range(0, 3));
      rv.rd  = 5'($urandom_range(0, 3));
      rv.fpc = $urandom;
      rv.es  = 0;
      rv.er  = 0;
      cyc(rv, 0, "rand");
    end
    cyc(mk(0, 0, 0, 0, S0, 0), 0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
